mul_share_arbiter: RTL
======================

// Module: mul_share_arbiter
// PURPOSE
//   Shares one pipelined unsigned multiplier among NUM_REQ requesters.
//   Sits between synthesized datapath circuits (one per requester) and a
//   single multiplier instance, so several circuits can time-share the resource.
//   Grants one request per cycle using round-robin priority.
//   Tags each operation and routes the product back to its owner after a
//   fixed latency.
// PARAMETERS
//   NUM_REQ     4   number of requesters (>=2)
//   DATAWIDTH   16  operand width; product is 2*DATAWIDTH
//   MUL_LATENCY 3   multiplier pipeline depth in cycles (>=1)
// PORTS
//   clk        in   1                    clock, rising edge
//   rst        in   1                    asynchronous reset, active-high
//   req_valid  in   NUM_REQ              bit i: requester i has an operation pending
//   req_a      in   NUM_REQ*DATAWIDTH    operand A, slice i belongs to requester i
//   req_b      in   NUM_REQ*DATAWIDTH    operand B, slice i belongs to requester i
//   req_ready  out  NUM_REQ              one-hot grant; accepted when valid&ready at posedge
//   rsp_valid  out  NUM_REQ              one-hot, 1-cycle pulse: result for requester i
//   rsp_data   out  2*DATAWIDTH          product, shared bus, qualified by rsp_valid
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - rr pointer=0 (requester 0 highest priority); all pipeline valid/tag bits=0.
//     - rsp_valid=0, rsp_data=0; req_ready=0 while rst is high.
//     - In-flight operations are discarded; no rsp_valid after reset release for them.
//   - Arbitration (combinational from req_valid and pointer):
//     - Priority order is ptr, ptr+1, ..., wrapping mod NUM_REQ.
//     - req_ready is one-hot to the first valid requester in that order; all-zero if none valid.
//     - ready never asserts for a requester whose valid is low.
//   - Pointer update on an accepted grant to requester g: ptr <= (g+1) mod NUM_REQ.
//     With no grant, ptr holds.
//   - Requester contract: hold valid and operands stable until ready.
//     Valid may drop only after acceptance.
//   - Issue: the accepted a,b and the one-hot tag enter stage 1.
//     Exactly one issue per cycle at most; the pipeline never stalls.
//   - Latency: accepted at posedge N -> rsp_valid=tag and rsp_data=a*b registered at
//     posedge N+MUL_LATENCY, held exactly 1 cycle. Back-to-back issues give
//     back-to-back responses in issue order.
//   - rsp_data holds its last value when rsp_valid=0 (no X, no clearing).
//   - Arithmetic: unsigned, full 2*DATAWIDTH product, no truncation or saturation.
//   - No response backpressure: owners must accept rsp_valid when it pulses.
//   - Simultaneous: a grant and a response in the same cycle are independent;
//     the same requester may be granted while its earlier result is in flight.
// CONFIGURATION
//   MUL_SHARE_STATS_EN defined: adds output ports
//     - stat_issued  out 32: count of accepted requests.
//     - stat_stalled out 32: count of cycles with any (req_valid & ~req_ready) bit set.
//     Both reset to 0, saturate at 32'hFFFFFFFF, count only while rst is low.
//   MUL_SHARE_STATS_EN undefined: these ports and counters do not exist;
//     all other behaviour is identical.
// TESTING
//   Checked against a behavioural model through error_monitor; clk_gen/rst_gen
//   supply clock and reset.
//   1. rst high 100ns, req_valid=4'hF -> req_ready=0, rsp_valid=0, rsp_data=0
//      throughout reset.
//   2. Only req 2 valid, a=3, b=5, accepted at posedge N -> rsp_valid=4'b0100,
//      rsp_data=15 at N+3, then rsp_valid=0.
//   3. req_valid=4'hF held for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in
//      the same order, 3 cycles after each grant.
//   4. ptr=0, only req 3 valid -> grant 3; next cycle req 0 and req 3 valid ->
//      grant 0 (wrap).
//   5. a=b=16'hFFFF -> rsp_data=32'hFFFE0001.
//   6. 3 operations in flight, rst pulsed 1 cycle -> no rsp_valid afterwards;
//      next grant follows ptr=0.
//      STATS_EN with test 3 -> stat_issued=8, stat_stalled=8.

Source files
------------

// File: rtl/mul_share_if.sv
// mul_share_if: request/response bundle between the requester circuits
// and the shared multiplier arbiter. The requester side uses the master
// modport and the arbiter uses the slave modport.
interface mul_share_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATAWIDTH = 16
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [2*DATAWIDTH-1:0]       rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: time-shares one pipelined unsigned multiplier among
// NUM_REQ requesters. Each cycle it grants at most one request in
// round-robin order. The owner is carried as a one-hot tag alongside the
// operands, and the product comes back on a shared bus MUL_LATENCY cycles
// after acceptance.
// Optional feature: define MUL_SHARE_STATS_EN to add the saturating
// stat_issued / stat_stalled counters.
module mul_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  mul_share_if.slave  bus
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stalled
`endif
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PROD_W = 2 * DATAWIDTH;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gidx_c;
  logic                 found_c;
  logic                 accept_c;
  logic [NUM_REQ-1:0]   grant_c;
  logic [DATAWIDTH-1:0] a_sel_c;
  logic [DATAWIDTH-1:0] b_sel_c;

  // Stage 0 holds the accepted operands; stages 1..MUL_LATENCY hold the
  // product, and the last stage drives the response bus.
  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [NUM_REQ-1:0]   tag_q  [MUL_LATENCY+1];
  logic [PROD_W-1:0]    prod_q [1:MUL_LATENCY];

  // Round-robin search: pick the first valid requester at or after ptr.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gidx_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_c && bus.req_valid[PTR_W'(idx)]) begin
        found_c = 1'b1;
        gidx_c  = PTR_W'(idx);
      end
    end
  end

  // One-hot grant, held low during reset, plus the operand mux for the winner.
  always_comb begin
    grant_c  = '0;
    a_sel_c  = '0;
    b_sel_c  = '0;
    accept_c = found_c && !rst;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx_c == PTR_W'(i)) begin
        grant_c[i] = accept_c;
        a_sel_c    = bus.req_a[i*DATAWIDTH +: DATAWIDTH];
        b_sel_c    = bus.req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign bus.req_ready = grant_c;

  // Priority pointer moves just past the requester that was granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept_c) begin
      ptr <= (32'(gidx_c) == NUM_REQ - 1) ? '0 : gidx_c + PTR_W'(1);
    end
  end

  // Issue stage: capture the operands and owner tag of the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      tag_q[0] <= '0;
    end else begin
      tag_q[0] <= grant_c;
      if (accept_c) begin
        a_q <= a_sel_c;
        b_q <= b_sel_c;
      end
    end
  end

  // Product pipeline. Data only moves with a valid tag, so the last stage
  // keeps the previous product while no response is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 1; k <= MUL_LATENCY; k++) begin
        tag_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      tag_q[1] <= tag_q[0];
      if (|tag_q[0]) prod_q[1] <= PROD_W'(a_q) * PROD_W'(b_q);
      for (int unsigned k = 2; k <= MUL_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
        if (|tag_q[k-1]) prod_q[k] <= prod_q[k-1];
      end
    end
  end

  assign bus.rsp_valid = tag_q[MUL_LATENCY];
  assign bus.rsp_data  = prod_q[MUL_LATENCY];

`ifdef MUL_SHARE_STATS_EN
  logic stall_c;
  assign stall_c = |(bus.req_valid & ~grant_c);

  // Saturating counters of accepted requests and of cycles with a waiting requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_stalled <= '0;
    end else begin
      if (accept_c && stat_issued != 32'hFFFF_FFFF) stat_issued <= stat_issued + 32'd1;
      if (stall_c && stat_stalled != 32'hFFFF_FFFF) stat_stalled <= stat_stalled + 32'd1;
    end
  end
`endif

endmodule
